// File: rtl/ones_accumulator.sv
// Frame-level accumulator for per-byte popcount beats: sums ones and beats per
// frame with saturation and illegal-count flagging, then holds the result until taken.
module ones_accumulator #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       num_ones,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_total,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] total, beats;
  logic             sat, err;

  logic             accept;
  logic             illegal;
  logic [3:0]       ones_clamped;
  logic [CNT_W-1:0] total_base, beats_base;
  logic             sat_base, err_base;
  logic [CNT_W:0]   total_sum, beats_sum;
  logic [CNT_W-1:0] total_nxt, beats_nxt;
  logic             sat_nxt, err_nxt;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // A beat taken in IDLE opens a new frame, so it accumulates onto zero rather
  // than onto whatever the previous frame left in the running registers.
  always_comb begin
    illegal      = (num_ones > 4'd8);
    ones_clamped = illegal ? 4'd8 : num_ones;

    if (state == IDLE) begin
      total_base = '0;
      beats_base = '0;
      sat_base   = 1'b0;
      err_base   = 1'b0;
    end else begin
      total_base = total;
      beats_base = beats;
      sat_base   = sat;
      err_base   = err;
    end

    total_sum = {1'b0, total_base} + {{(CNT_W-3){1'b0}}, ones_clamped};
    beats_sum = {1'b0, beats_base} + {{CNT_W{1'b0}}, 1'b1};

    total_nxt = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
    beats_nxt = beats_sum[CNT_W] ? '1 : beats_sum[CNT_W-1:0];
    sat_nxt   = sat_base | total_sum[CNT_W] | beats_sum[CNT_W];
    err_nxt   = err_base | illegal;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = in_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (accept && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      total <= '0;
      beats <= '0;
      sat   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        total <= total_nxt;
        beats <= beats_nxt;
        sat   <= sat_nxt;
        err   <= err_nxt;
      end
    end
  end

  // Result registers are loaded with the final beat included and zeroed on the
  // handshake, so they read zero whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_total <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept && in_last) begin
      out_total <= total_nxt;
      out_beats <= beats_nxt;
      out_sat   <= sat_nxt;
      out_err   <= err_nxt;
    end else if (state == HOLD && out_ready) begin
      out_total <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ones_accumulator.sv
// Scoreboard bench for ones_accumulator: default-width instance for the main
// scenarios and a CNT_W=4 instance for saturation boundaries.
module tb_ones_accumulator;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_last, out_ready;
  logic [3:0]   num_ones;
  logic         in_ready, out_valid, out_sat, out_err;
  logic [W-1:0] out_total, out_beats;

  logic         v4, last4, ordy4;
  logic [3:0]   ones4;
  logic         ir4, ov4, sat4, err4;
  logic [3:0]   tot4, bt4;

  always #5 clk = ~clk;

  ones_accumulator #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num_ones(num_ones), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_total(out_total), .out_beats(out_beats),
    .out_sat(out_sat), .out_err(out_err)
  );

  ones_accumulator #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4),
    .num_ones(ones4), .in_last(last4), .out_valid(ov4),
    .out_ready(ordy4), .out_total(tot4), .out_beats(bt4),
    .out_sat(sat4), .out_err(err4)
  );

  typedef struct {
    int unsigned total;
    int unsigned beats;
    bit          sat;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t model_frame(input int unsigned v[$], input int unsigned lim);
    exp_t r;
    r.total = 0; r.beats = 0; r.sat = 1'b0; r.err = 1'b0;
    foreach (v[i]) begin
      int unsigned c;
      c = (v[i] > 8) ? 8 : v[i];
      if (v[i] > 8) r.err = 1'b1;
      if (r.total + c > lim) begin r.total = lim; r.sat = 1'b1; end
      else r.total = r.total + c;
      if (r.beats + 1 > lim) begin r.beats = lim; r.sat = 1'b1; end
      else r.beats = r.beats + 1;
    end
    return r;
  endfunction

  function automatic logic [26:0] pack12(input exp_t e);
    return {1'b1, e.sat, e.err, 12'(e.beats), 12'(e.total)};
  endfunction

  function automatic logic [10:0] pack4(input exp_t e);
    return {1'b1, e.sat, e.err, 4'(e.beats), 4'(e.total)};
  endfunction

  // Drives one frame back-to-back into the default instance (caller ensures it
  // is accepting) and queues the model result; entered and left at a negedge.
  task automatic send_frame(input int unsigned v[$]);
    exp_q.push_back(model_frame(v, 4095));
    foreach (v[i]) begin
      in_valid = 1'b1;
      num_ones = 4'(v[i]);
      in_last  = (i == v.size() - 1);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] got;
    logic [11:0] got4;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {in_ready, out_valid, out_sat, out_err, out_beats, out_total};
    n_vec++;
    if (got !== {1'b1, 27'd0}) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", got, {1'b1, 27'd0});
    end
    got4 = {ir4, ov4, sat4, err4, bt4, tot4};
    n_vec++;
    if (got4 !== {1'b1, 11'd0}) begin
      n_err++; $display("FAIL reset_state4 got=%h exp=%h", got4, {1'b1, 11'd0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    logic [26:0] got;
    out_ready = 1'b1;
    send_frame('{3, 8, 0, 5});
    e = exp_q.pop_front();
    got = {out_valid, out_sat, out_err, out_beats, out_total};
    n_vec++;
    if (got !== pack12(e)) begin
      n_err++; $display("FAIL basic_result got=%h exp=%h", got, pack12(e));
    end
    @(posedge clk); @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, out_total} !== {1'b1, 1'b0, 12'd0}) begin
      n_err++; $display("FAIL basic_idle got=%h exp=%h", {in_ready, out_valid, out_total}, {1'b1, 1'b0, 12'd0});
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic [27:0] got;
    out_ready = 1'b0;
    send_frame('{7});
    e = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      got = {in_ready, out_valid, out_sat, out_err, out_beats, out_total};
      n_vec++;
      if (got !== {1'b0, pack12(e)}) begin
        n_err++; $display("FAIL hold_stable cyc=%0d got=%h exp=%h", i, got, {1'b0, pack12(e)});
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL hold_release got=%b exp=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_err();
    exp_t e;
    logic [26:0] got;
    out_ready = 1'b1;
    send_frame('{12, 2});
    e = exp_q.pop_front();
    got = {out_valid, out_sat, out_err, out_beats, out_total};
    n_vec++;
    if (got !== pack12(e)) begin
      n_err++; $display("FAIL err_clamp got=%h exp=%h", got, pack12(e));
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_sat();
    exp_t e;
    logic [10:0] got;
    int unsigned f[$];
    ordy4 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      f.delete();
      if (s == 0) f = '{8, 8, 8};
      else if (s == 1) for (int k = 0; k < 17; k++) f.push_back(0);
      else f = '{3, 4};
      exp_q.push_back(model_frame(f, 15));
      foreach (f[i]) begin
        v4 = 1'b1; ones4 = 4'(f[i]); last4 = (i == f.size() - 1);
        @(posedge clk); @(negedge clk);
      end
      v4 = 1'b0; last4 = 1'b0;
      e = exp_q.pop_front();
      got = {ov4, sat4, err4, bt4, tot4};
      n_vec++;
      if (got !== pack4(e)) begin
        n_err++; $display("FAIL sat4_case%0d got=%h exp=%h", s, got, pack4(e));
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    logic [27:0] got;
    logic [26:0] res;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; num_ones = 4'd6; in_last = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0; in_valid = 1'b1; num_ones = 4'd5; in_last = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {in_ready, out_valid, out_sat, out_err, out_beats, out_total};
      n_vec++;
      if (got !== {1'b1, 27'd0}) begin
        n_err++; $display("FAIL midreset_quiet cyc=%0d got=%h exp=%h", i, got, {1'b1, 27'd0});
      end
      @(posedge clk); @(negedge clk);
    end
    send_frame('{1});
    e = exp_q.pop_front();
    res = {out_valid, out_sat, out_err, out_beats, out_total};
    n_vec++;
    if (res !== pack12(e)) begin
      n_err++; $display("FAIL midreset_frame got=%h exp=%h", res, pack12(e));
    end
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    send_frame('{6});
    e = exp_q.pop_front();
    res = {out_valid, out_sat, out_err, out_beats, out_total};
    n_vec++;
    if (res !== pack12(e)) begin
      n_err++; $display("FAIL holdreset_pre got=%h exp=%h", res, pack12(e));
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    got = {in_ready, out_valid, out_sat, out_err, out_beats, out_total};
    n_vec++;
    if (got !== {1'b1, 27'd0}) begin
      n_err++; $display("FAIL holdreset_post got=%h exp=%h", got, {1'b1, 27'd0});
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int unsigned a[$];
    int unsigned b[$];
    int unsigned vals[$];
    bit lasts[$];
    int results, hs_cyc, b_cyc, idx;
    exp_t e;
    logic [26:0] got;
    a = '{2, 3};
    b = '{4, 4, 1};
    results = 0; hs_cyc = -1; b_cyc = -1; idx = 0;
    out_ready = 1'b1;
    exp_q.push_back(model_frame(a, 4095));
    exp_q.push_back(model_frame(b, 4095));
    foreach (a[i]) begin vals.push_back(a[i]); lasts.push_back(i == a.size() - 1); end
    foreach (b[i]) begin vals.push_back(b[i]); lasts.push_back(i == b.size() - 1); end
    for (int cyc = 0; cyc < 40 && results < 2; cyc++) begin
      if (idx < vals.size()) begin
        in_valid = 1'b1; num_ones = 4'(vals[idx]); in_last = lasts[idx];
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      if (out_valid) begin
        e = exp_q.pop_front();
        got = {out_valid, out_sat, out_err, out_beats, out_total};
        n_vec++;
        if (got !== pack12(e)) begin
          n_err++; $display("FAIL b2b_result%0d got=%h exp=%h", results, got, pack12(e));
        end
        if (hs_cyc < 0) hs_cyc = cyc;
        results++;
      end
      if (in_valid && in_ready) begin
        if (idx == a.size()) b_cyc = cyc;
        idx++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_vec++;
    if (results != 2) begin
      n_err++; $display("FAIL b2b_timeout results=%0d exp=2", results);
      exp_q.delete();
    end
    n_vec++;
    if (b_cyc != hs_cyc + 1) begin
      n_err++; $display("FAIL b2b_restart accept_cyc=%0d exp=%0d", b_cyc, hs_cyc + 1);
    end
  endtask

  task automatic test_random();
    int unsigned vals[$];
    bit lasts[$];
    int frames_done, idx;
    bit offering;
    exp_t e;
    logic [26:0] got;
    frames_done = 0; idx = 0; offering = 1'b0;
    exp_q.delete();
    for (int f = 0; f < 20; f++) begin
      int unsigned fv[$];
      int unsigned len;
      len = $urandom_range(1, 6);
      for (int unsigned k = 0; k < len; k++) begin
        fv.push_back($urandom_range(0, 15));
        vals.push_back(fv[k]);
        lasts.push_back(k == len - 1);
      end
      exp_q.push_back(model_frame(fv, 4095));
    end
    for (int cyc = 0; cyc < 2000 && frames_done < 20; cyc++) begin
      if (!offering && idx < vals.size()) offering = ($urandom_range(0, 3) != 0);
      if (offering) begin
        in_valid = 1'b1; num_ones = 4'(vals[idx]); in_last = lasts[idx];
      end else begin
        in_valid = 1'b0; num_ones = 4'($urandom_range(0, 15)); in_last = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected got=1 exp=0");
        end else begin
          e = exp_q[0];
          got = {out_valid, out_sat, out_err, out_beats, out_total};
          if (got !== pack12(e)) begin
            n_err++; $display("FAIL rand_frame%0d got=%h exp=%h", frames_done, got, pack12(e));
          end
          if (out_ready) begin
            exp_q.delete(0);
            frames_done++;
          end
        end
      end else begin
        n_vec++;
        if ({out_sat, out_err, out_beats, out_total} !== 26'd0) begin
          n_err++; $display("FAIL rand_idle_zero got=%h exp=0", {out_sat, out_err, out_beats, out_total});
        end
      end
      if (in_valid && in_ready) begin
        idx++;
        offering = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (frames_done != 20) begin
      n_err++; $display("FAIL rand_timeout frames=%0d exp=20", frames_done);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; num_ones = 4'd0; out_ready = 1'b1;
    v4 = 1'b0; last4 = 1'b0; ones4 = 4'd0; ordy4 = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_err();
    test_sat();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
